// File: rtl/microsequencer.sv
// Next-state sequencer for the multicycle MIPS control unit; owns the microprogram state register.
// Define MICROSEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into an absorbing HALT state.
module microsequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             addrctl,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             stall,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    JEX     = 4'd9,
    HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t state_q;
  state_t state_d;
  logic   illegal_d;
  logic   retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    state_d   = state_q;
    illegal_d = 1'b0;
    if (stall) begin
      state_d = state_q;
    end else if (state_q == HALT) begin
      state_d = TRAP_EN ? HALT : FETCH;
    end else if (state_q > JEX) begin
      state_d = FETCH;
    end else if (addrctl) begin
      state_d = (state_q == JEX) ? FETCH : state_t'(state_q + 4'd1);
    end else begin
      case (state_q)
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = RTYPEEX;
            OP_BEQ:       state_d = BEQEX;
            OP_J:         state_d = JEX;
            default: begin
              state_d   = TRAP_EN ? HALT : FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          case (opcode)
            OP_LW:   state_d = MEMRD;
            OP_SW:   state_d = MEMWR;
            default: state_d = FETCH;
          endcase
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    stall  = !mem_ready && (state_q == FETCH || state_q == MEMRD || state_q == MEMWR);
    halted = TRAP_EN && (state_q == HALT);
    // An instruction retires on the edge that returns to FETCH from elsewhere.
    retire = (state_q != FETCH) && (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      illegal <= illegal_d;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: instruction-level reference model with random stalls and opcodes.
module tb_microsequencer;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic        clk = 1'b0;
  logic        reset;
  logic        addrctl;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic [3:0]  state, state_s;
  logic        stall, stall_s;
  logic        illegal, illegal_s;
  logic        halted, halted_s;
  logic [15:0] instr_count;
  logic [3:0]  instr_count_s;

  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  logic exp_illegal = 1'b0;
  int   path[$];

  microsequencer dut (
    .clk(clk), .reset(reset), .addrctl(addrctl), .opcode(opcode), .mem_ready(mem_ready),
    .state(state), .stall(stall), .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );

  microsequencer #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .addrctl(addrctl), .opcode(opcode), .mem_ready(mem_ready),
    .state(state_s), .stall(stall_s), .illegal(illegal_s), .halted(halted_s),
    .instr_count(instr_count_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  // addrctl bit a correct microprogram ROM holds at each state
  function automatic logic rom_addrctl(input int s);
    return (s == 0 || s == 3 || s == 6);
  endfunction

  // Microstate walk of one instruction: DECODE dispatches on op, MEMADR on op2.
  task automatic build_path(input logic [5:0] op, input logic [5:0] op2);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      OP_LW, OP_SW: begin
        path.push_back(2);
        if (op2 == OP_LW) begin
          path.push_back(3);
          path.push_back(4);
        end else if (op2 == OP_SW) begin
          path.push_back(5);
        end
      end
      OP_R: begin
        path.push_back(6);
        path.push_back(7);
      end
      OP_BEQ: path.push_back(8);
      OP_J:   path.push_back(9);
      default: ;
    endcase
  endtask

  // Entered at posedge+1: drive one cycle, check at posedge+2, return at next posedge+1.
  task automatic step(input int s, input bit stalled, input logic [5:0] op, input logic [5:0] op2);
    bit mem_state;
    mem_state = (s == 0 || s == 3 || s == 5);
    addrctl   = rom_addrctl(s);
    mem_ready = mem_state ? !stalled : 1'($urandom);
    opcode    = (s == 1) ? op : (s == 2) ? op2 : 6'($urandom);
    #1;
    checks++;
    if (state !== 4'(s) || state_s !== 4'(s)) begin
      errors++;
      $display("FAIL state: got %0d/%0d expected %0d at %0t", state, state_s, s, $time);
    end
    checks++;
    if (stall !== stalled || stall_s !== stalled) begin
      errors++;
      $display("FAIL stall: got %b/%b expected %b at %0t", stall, stall_s, stalled, $time);
    end
    checks++;
    if (illegal !== exp_illegal || illegal_s !== exp_illegal) begin
      errors++;
      $display("FAIL illegal: got %b/%b expected %b at %0t", illegal, illegal_s, exp_illegal, $time);
    end
    checks++;
    if (halted !== 1'b0 || halted_s !== 1'b0) begin
      errors++;
      $display("FAIL halted: got %b/%b expected 0 at %0t", halted, halted_s, $time);
    end
    exp_illegal = (s == 1) && !is_legal(op);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] op2,
                           input int st_fetch, input int st_rd, input int st_wr);
    int n;
    build_path(op, op2);
    foreach (path[i]) begin
      n = (path[i] == 0) ? st_fetch : (path[i] == 3) ? st_rd : (path[i] == 5) ? st_wr : 0;
      for (int k = 0; k <= n; k++) step(path[i], k < n, op, op2);
    end
    exp_count++;
    checks++;
    if (instr_count !== 16'(exp_count) || instr_count_s !== 4'(exp_count) || state !== 4'd0) begin
      errors++;
      $display("FAIL retire: count %0d/%0d state %0d expected count %0d state 0",
               instr_count, instr_count_s, state, exp_count);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    addrctl   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    exp_count   = 0;
    exp_illegal = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    addrctl   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || instr_count !== 16'd0 || illegal !== 1'b0 || halted !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: state %0d count %0d illegal %b halted %b stall %b expected 0",
               state, instr_count, illegal, halted, stall);
    end
    reset       = 1'b1;
    exp_count   = 0;
    exp_illegal = 1'b0;
    step(0, 1'b0, OP_R, OP_R);
    step(1, 1'b0, OP_R, OP_R);
    checks++;
    if (state !== 4'd6) begin
      errors++;
      $display("FAIL reach_rtypeex: got %0d expected 6", state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || state_s !== 4'd0 || instr_count !== 16'd0 || instr_count_s !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: state %0d count %0d expected 0 0", state, instr_count);
    end
    addrctl   = 1'b1;
    mem_ready = 1'b1;
    #5;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL first_edge: state %0d count %0d expected 1 0", state, instr_count);
    end
    do_reset();
  endtask

  task automatic test_lw_sw();
    run_instr(OP_LW, OP_LW, 0, 0, 0);
    run_instr(OP_SW, OP_SW, 0, 0, 0);
  endtask

  task automatic test_mem_stall();
    run_instr(OP_LW, OP_LW, 0, 3, 0);
    run_instr(OP_SW, OP_SW, 2, 0, 1);
  endtask

  task automatic test_back_to_back();
    int base;
    base = exp_count;
    run_instr(OP_R,   OP_R,   0, 0, 0);
    run_instr(OP_BEQ, OP_BEQ, 0, 0, 0);
    run_instr(OP_J,   OP_J,   0, 0, 0);
    checks++;
    if (instr_count !== 16'(base + 3)) begin
      errors++;
      $display("FAIL back_to_back: count %0d expected %0d", instr_count, base + 3);
    end
  endtask

  task automatic test_memadr_other();
    run_instr(OP_LW, OP_R,   0, 0, 0);
    run_instr(OP_SW, OP_BEQ, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[5];
    logic [5:0] op, op2;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    repeat (40) begin
      op  = ops[$urandom_range(0, 4)];
      op2 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op;
      run_instr(op, op2,
                $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
                $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
                $urandom_range(0, 1) ? 0 : $urandom_range(1, 3));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (16) run_instr(OP_J, OP_J, 0, 0, 0);
    checks++;
    if (instr_count_s !== 4'd0 || instr_count !== 16'd16) begin
      errors++;
      $display("FAIL wrap: small %0d wide %0d expected 0 16", instr_count_s, instr_count);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    do op = 6'($urandom); while (is_legal(op));
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    step(0, 1'b0, op, op);
    step(1, 1'b0, op, op);
    for (int i = 0; i < 20; i++) begin
      addrctl   = 1'($urandom);
      mem_ready = 1'($urandom);
      opcode    = 6'($urandom);
      #1;
      checks++;
      if (state !== 4'd15 || state_s !== 4'd15 || halted !== 1'b1 || halted_s !== 1'b1 ||
          illegal !== (i == 0) || stall !== 1'b0 || instr_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL halt_cycle%0d: state %0d halted %b illegal %b stall %b count %0d expected 15 1 %b 0 %0d",
                 i, state, halted, illegal, stall, instr_count, i == 0, exp_count);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL halt_reset: state %0d halted %b count %0d expected 0 0 0", state, halted, instr_count);
    end
`else
    run_instr(op, op, 0, 0, 0);
    run_instr(OP_J, OP_J, 0, 0, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_lw_sw();
    test_mem_stall();
    test_back_to_back();
    test_memadr_other();
    test_random();
    test_wrap();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
